// File: rtl/sim_run_controller.sv
// Run-phase sequencer for the cycle-level simulator: IDLE -> WARMUP -> MEASURE -> DRAIN -> DONE.
// It gates the datapath's per-cycle advance, counts enabled cycles and flags drain timeouts.
module sim_run_controller #(
  parameter int MAX_CYCLE_WIDTH = 5,
  parameter int DRAIN_LIMIT     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pause,
  input  logic                       step,
  input  logic [MAX_CYCLE_WIDTH-1:0] warmup_cycles,
  input  logic [MAX_CYCLE_WIDTH-1:0] measure_cycles,
  input  logic                       drained,
  output logic                       sim_enable,
  output logic                       stats_enable,
  output logic [2:0]                 phase,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);
  localparam int W = MAX_CYCLE_WIDTH;
  localparam logic [W-1:0] DRAIN_LAST = W'(DRAIN_LIMIT - 1);
  localparam logic [W-1:0] CYC_MAX    = '1;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_WARMUP  = 3'd1,
    PH_MEASURE = 3'd2,
    PH_DRAIN   = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  phase_e         phase_q, phase_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   cyc_q, cyc_d;
  logic [W-1:0]   warm_q, warm_d;
  logic [W-1:0]   meas_q, meas_d;
  logic           tmo_q, tmo_d;
  logic           busy_w, en_w;

  assign busy_w = (phase_q == PH_WARMUP) || (phase_q == PH_MEASURE) || (phase_q == PH_DRAIN);
  assign en_w   = busy_w && (!pause || step);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    warm_d  = warm_q;
    meas_d  = meas_q;
    tmo_d   = tmo_q;
    if (abort) begin
      // abort also blocks a start in IDLE, where it otherwise does nothing
      if (phase_q != PH_IDLE) begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
        cyc_d   = '0;
        tmo_d   = 1'b0;
      end
    end else if (start && !busy_w) begin
      warm_d = warmup_cycles;
      meas_d = measure_cycles;
      cnt_d  = '0;
      cyc_d  = '0;
      tmo_d  = 1'b0;
      if (warmup_cycles != '0)       phase_d = PH_WARMUP;
      else if (measure_cycles != '0) phase_d = PH_MEASURE;
      else                           phase_d = PH_DRAIN;
    end else if (en_w) begin
      cnt_d = cnt_q + 1'b1;
      cyc_d = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
      case (phase_q)
        PH_WARMUP: if (cnt_q == warm_q - 1'b1) begin
          // an empty measure budget skips straight to DRAIN
          phase_d = (meas_q != '0) ? PH_MEASURE : PH_DRAIN;
          cnt_d   = '0;
        end
        PH_MEASURE: if (cnt_q == meas_q - 1'b1) begin
          phase_d = PH_DRAIN;
          cnt_d   = '0;
        end
        PH_DRAIN: if (drained) begin
          phase_d = PH_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else if (cnt_q == DRAIN_LAST) begin
          phase_d = PH_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      warm_q  <= '0;
      meas_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      warm_q  <= warm_d;
      meas_q  <= meas_d;
      tmo_q   <= tmo_d;
    end
  end

  assign sim_enable    = en_w;
  assign stats_enable  = en_w && (phase_q == PH_MEASURE);
  assign phase         = phase_q;
  assign current_cycle = cyc_q;
  assign busy          = busy_w;
  assign done          = (phase_q == PH_DONE);
  assign timeout_err   = tmo_q;
endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: a remaining-cycles run model checked every negedge,
// plus hand-computed literal checkpoints along each scenario.
module tb_sim_run_controller;
  localparam int W   = 5;
  localparam int DL  = 4;
  localparam int SAT = 31;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, pause = 1'b0, step = 1'b0, drained = 1'b0;
  logic [W-1:0] warmup_cycles = '0, measure_cycles = '0;
  logic         sim_enable, stats_enable, busy, done, timeout_err;
  logic [2:0]   phase;
  logic [W-1:0] current_cycle;

  int n_chk = 0;
  int n_fail = 0;

  sim_run_controller #(.MAX_CYCLE_WIDTH(W), .DRAIN_LIMIT(DL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .pause(pause), .step(step),
    .warmup_cycles(warmup_cycles), .measure_cycles(measure_cycles), .drained(drained),
    .sim_enable(sim_enable), .stats_enable(stats_enable), .phase(phase),
    .current_cycle(current_cycle), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phases as ints, each phase tracked by cycles remaining; total cycles unbounded.
  int m_phase = 0, m_rem = 0, m_total = 0, m_wb = 0, m_mb = 0;
  bit m_tmo = 0;

  function automatic bit m_busy();
    return m_phase >= 1 && m_phase <= 3;
  endfunction

  task automatic m_enter_after_warmup();
    if (m_mb > 0) begin m_phase = 2; m_rem = m_mb; end
    else begin m_phase = 3; m_rem = DL; end
  endtask

  always @(negedge reset_n) begin
    m_phase = 0; m_rem = 0; m_total = 0; m_wb = 0; m_mb = 0; m_tmo = 0;
  end

  always @(posedge clk) if (reset_n) begin
    bit en;
    en = m_busy() && (!pause || step);
    if (abort) begin
      if (m_phase != 0) begin m_phase = 0; m_total = 0; m_tmo = 0; m_rem = 0; end
    end else if (start && !m_busy()) begin
      m_wb = int'(warmup_cycles); m_mb = int'(measure_cycles);
      m_total = 0; m_tmo = 0;
      if (m_wb > 0) begin m_phase = 1; m_rem = m_wb; end
      else m_enter_after_warmup();
    end else if (en) begin
      m_total++;
      case (m_phase)
        1: begin m_rem--; if (m_rem == 0) m_enter_after_warmup(); end
        2: begin m_rem--; if (m_rem == 0) begin m_phase = 3; m_rem = DL; end end
        3: if (drained) begin m_phase = 4; m_tmo = 0; end
           else begin m_rem--; if (m_rem == 0) begin m_phase = 4; m_tmo = 1; end end
        default: ;
      endcase
    end
  end

  always @(negedge clk) if (reset_n) begin
    bit en;
    en = m_busy() && (!pause || step);
    chk("sim_enable", sim_enable, en);
    chk("stats_enable", stats_enable, en && m_phase == 2);
    chk("phase", phase, m_phase);
    chk("current_cycle", current_cycle, (m_total > SAT) ? SAT : m_total);
    chk("busy", busy, m_busy());
    chk("done", done, m_phase == 4);
    chk("timeout_err", timeout_err, m_tmo);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_start(input int w, input int m);
    warmup_cycles = W'(w); measure_cycles = W'(m); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset phase", phase, 0);
    chk("reset sim_enable", sim_enable, 0);
    chk("reset cycle", current_cycle, 0);
    chk("reset done", done, 0);
    #10 reset_n = 1'b1;
    tick();

    // 1: basic run 3/4, drained
    drained = 1'b1;
    run_start(3, 4);
    chk("t1 warmup entry", phase, 1);
    chk("t1 cycle zero", current_cycle, 0);
    tick(3);
    chk("t1 measure entry", phase, 2);
    chk("t1 stats_enable", stats_enable, 1);
    tick(5);
    chk("t1 done", done, 1);
    chk("t1 cycle", current_cycle, 8);
    chk("t1 timeout", timeout_err, 0);

    // 2: pause with single step mid-MEASURE
    run_start(1, 10);
    tick(3);
    chk("t2 cycle pre-pause", current_cycle, 3);
    pause = 1'b1;
    tick(6);
    chk("t2 paused cycle", current_cycle, 3);
    chk("t2 paused en", sim_enable, 0);
    step = 1'b1;
    #1 chk("t2 step en", sim_enable, 1);
    tick();
    step = 1'b0;
    chk("t2 stepped cycle", current_cycle, 4);
    tick(3);
    chk("t2 frozen cycle", current_cycle, 4);
    pause = 1'b0;
    tick(8);
    chk("t2 done", done, 1);
    chk("t2 cycle", current_cycle, 12);

    // 3: drain timeout, then drained on the limit cycle
    drained = 1'b0;
    run_start(1, 1);
    tick(2);
    chk("t3 drain entry", phase, 3);
    tick(3);
    chk("t3 still draining", phase, 3);
    tick();
    chk("t3 done", phase, 4);
    chk("t3 timeout", timeout_err, 1);
    chk("t3 cycle", current_cycle, 6);
    run_start(2, 1);
    chk("t3 timeout cleared", timeout_err, 0);
    tick(6);
    chk("t3b drain count", phase, 3);
    drained = 1'b1;
    tick();
    chk("t3b done", phase, 4);
    chk("t3b no timeout", timeout_err, 0);
    chk("t3b cycle", current_cycle, 7);

    // 4: start while busy ignored; abort beats start
    run_start(2, 5);
    warmup_cycles = 5'd7; measure_cycles = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4 ignored start", phase, 1);
    chk("t4 ignored cycle", current_cycle, 1);
    tick(3);
    chk("t4 budget kept", phase, 2);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t4 abort phase", phase, 0);
    chk("t4 abort cycle", current_cycle, 0);
    chk("t4 abort busy", busy, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4 abort idle", phase, 0);

    // 5: zero budgets, then saturating budgets
    drained = 1'b1;
    run_start(0, 0);
    chk("t5 direct drain", phase, 3);
    tick();
    chk("t5 done", phase, 4);
    chk("t5 cycle", current_cycle, 1);
    drained = 1'b0;
    run_start(31, 31);
    warmup_cycles = 5'd5; measure_cycles = 5'd2;
    tick(31);
    chk("t5 measure entry", phase, 2);
    chk("t5 cycle 31", current_cycle, 31);
    tick(31);
    chk("t5 drain entry", phase, 3);
    chk("t5 saturated", current_cycle, 31);
    tick(4);
    chk("t5 timeout done", phase, 4);
    chk("t5 timeout", timeout_err, 1);

    // 6: asynchronous reset between edges
    drained = 1'b1;
    run_start(5, 5);
    tick(3);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 async phase", phase, 0);
    chk("t6 async en", sim_enable, 0);
    chk("t6 async cycle", current_cycle, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
